// File: rtl/multdiv_controller_if.sv
// multdiv_controller_if: processor-side and datapath-side signals of the multdiv controller.
// MULTDIV_REMAINDER_EN adds the signed remainder result.
interface multdiv_controller_if #(parameter int WIDTH = 32);
  logic ctrl_MULT;
  logic ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] dp_operandA;
  logic [WIDTH-1:0] dp_operandB;
  logic dp_mult_start;
  logic dp_div_start;
  logic [WIDTH-1:0] dp_mult_product;
  logic dp_mult_overflow;
  logic dp_mult_ready;
  logic [WIDTH-1:0] dp_div_quotient;
  logic [WIDTH-1:0] dp_div_remainder;
  logic dp_div_ready;
  logic [WIDTH-1:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output dp_mult_product, dp_mult_overflow, dp_mult_ready,
    output dp_div_quotient, dp_div_remainder, dp_div_ready,
    input dp_operandA, dp_operandB, dp_mult_start, dp_div_start,
    input data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
    , input data_remainder
`endif
  );
  modport slave (
    input ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input dp_mult_product, dp_mult_overflow, dp_mult_ready,
    input dp_div_quotient, dp_div_remainder, dp_div_ready,
    output dp_operandA, dp_operandB, dp_mult_start, dp_div_start,
    output data_result, data_exception, data_resultRDY, busy
`ifdef MULTDIV_REMAINDER_EN
    , output data_remainder
`endif
  );
endinterface

// File: rtl/multdiv_controller.sv
// multdiv_controller: sequences one multiply or divide, applies sign correction, pulses ready.
// MULTDIV_REMAINDER_EN adds a registered signed remainder output.
module multdiv_controller #(
  parameter int WIDTH = 32,
  parameter int MAX_CYCLES = 40
) (
  input logic clock,
  input logic reset,
  multdiv_controller_if.slave bus
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, START, RUN, FIX, DONE} state_t;
  state_t state;
  logic op_div, sign_a, sign_b, timeout, div_zero;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic go, go_div, b_zero, ready_sel, div_ovf, fix_exc;
  logic [WIDTH-1:0] abs_a, abs_b, q_signed, fix_result;
  assign go = bus.ctrl_MULT | bus.ctrl_DIV;
  assign go_div = !bus.ctrl_MULT;
  assign b_zero = bus.data_operandB == '0;
  assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign ready_sel = op_div ? bus.dp_div_ready : bus.dp_mult_ready;
  assign div_ovf = (a_q == MIN_NEG) && (b_q == '1);
  always_comb begin
    q_signed = (sign_a ^ sign_b) ? -bus.dp_div_quotient : bus.dp_div_quotient;
    fix_result = (timeout || div_zero) ? '0 : !op_div ? bus.dp_mult_product : div_ovf ? MIN_NEG : q_signed;
    fix_exc = timeout || div_zero || (op_div ? div_ovf : bus.dp_mult_overflow);
  end
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] fix_rem;
  assign fix_rem = (timeout || div_zero || !op_div) ? '0 :
                   sign_a ? -bus.dp_div_remainder : bus.dp_div_remainder;
`endif
  // A ctrl pulse in any state restarts the sequence and discards the op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      timeout <= 1'b0;
      div_zero <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      bus.dp_operandA <= '0;
      bus.dp_operandB <= '0;
      bus.dp_mult_start <= 1'b0;
      bus.dp_div_start <= 1'b0;
      bus.data_result <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      bus.data_remainder <= '0;
`endif
    end else begin
      bus.dp_mult_start <= 1'b0;
      bus.dp_div_start <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      if (go) begin
        op_div <= go_div;
        a_q <= bus.data_operandA;
        b_q <= bus.data_operandB;
        sign_a <= bus.data_operandA[WIDTH-1];
        sign_b <= bus.data_operandB[WIDTH-1];
        bus.dp_operandA <= go_div ? abs_a : bus.data_operandA;
        bus.dp_operandB <= go_div ? abs_b : bus.data_operandB;
        timeout <= 1'b0;
        div_zero <= go_div && b_zero;
        cnt <= '0;
        bus.dp_mult_start <= !go_div;
        bus.dp_div_start <= go_div && !b_zero;
        bus.busy <= 1'b1;
        state <= (go_div && b_zero) ? FIX : START;
      end else begin
        case (state)
          START: state <= RUN;
          RUN: begin
            cnt <= cnt + 1'b1;
            if (ready_sel) state <= FIX;
            else if (cnt == CW'(MAX_CYCLES - 1)) begin
              timeout <= 1'b1;
              state <= FIX;
            end
          end
          FIX: begin
            bus.data_result <= fix_result;
            bus.data_exception <= fix_exc;
`ifdef MULTDIV_REMAINDER_EN
            bus.data_remainder <= fix_rem;
`endif
            bus.data_resultRDY <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            bus.busy <= 1'b0;
            state <= IDLE;
          end
          default: begin
            bus.busy <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_controller.sv
// tb_multdiv_controller: directed vector table plus abort, timeout and async-reset sequences.
module tb_multdiv_controller;
  typedef struct {
    int op;
    logic [31:0] a, b, prod;
    logic ovf;
    logic [31:0] q, r;
    int lat;
    logic [31:0] opa, opb, res;
    logic exc;
    logic [31:0] rem;
    int rdy_at;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  int rdy_cnt = 0;
  int since, lat;
  logic hold, m_div;
  vec_t vec [12];
  multdiv_controller_if #(.WIDTH(32)) bus ();
  multdiv_controller #(.WIDTH(32), .MAX_CYCLES(40)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  always @(posedge clock or posedge reset)
    if (reset) begin
      since <= 0;
      m_div <= 1'b0;
    end else if (bus.dp_mult_start || bus.dp_div_start) begin
      since <= 0;
      m_div <= bus.dp_div_start;
    end else since <= since + 1;
  assign bus.dp_mult_ready = !hold && !m_div && since >= lat;
  assign bus.dp_div_ready = !hold && m_div && since >= lat;
  always @(negedge clock) if (bus.data_resultRDY) rdy_cnt <= rdy_cnt + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = (op != 1);
    bus.ctrl_DIV = (op != 0);
    bus.data_operandA = a;
    bus.data_operandB = b;
    tick();
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
  endtask
  task automatic wait_rdy(output int n);
    n = 1;
    while (!bus.data_resultRDY && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic set_dp(input logic [31:0] prod, input logic ovf, input logic [31:0] q,
                        input logic [31:0] r, input int l);
    bus.dp_mult_product = prod;
    bus.dp_mult_overflow = ovf;
    bus.dp_div_quotient = q;
    bus.dp_div_remainder = r;
    lat = l;
  endtask
  initial begin
    int n, rc;
    logic [31:0] prev;
    vec[0]  = '{0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32'h0, 32'h0, 17, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 32'h0, 21};
    vec[1]  = '{1, 32'hFFFFFFEF, 32'h5, 32'h0, 1'b0, 32'h3, 32'h2, 5, 32'h11, 32'h5, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFE, 9};
    vec[2]  = '{1, 32'h64, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h64, 32'h0, 32'h0, 1'b1, 32'h0, 2};
    vec[3]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h80000000, 32'h0, 3, 32'h80000000, 32'h1, 32'h80000000, 1'b1, 32'h0, 7};
    vec[4]  = '{0, 32'h10000, 32'h10000, 32'h0, 1'b1, 32'h0, 32'h0, 2, 32'h10000, 32'h10000, 32'h0, 1'b1, 32'h0, 6};
    vec[5]  = '{1, 32'h14, 32'hFFFFFFFA, 32'h0, 1'b0, 32'h3, 32'h2, 4, 32'h14, 32'h6, 32'hFFFFFFFD, 1'b0, 32'h2, 8};
    vec[6]  = '{1, 32'hFFFFFFEC, 32'hFFFFFFFA, 32'h0, 1'b0, 32'h3, 32'h2, 1, 32'h14, 32'h6, 32'h3, 1'b0, 32'hFFFFFFFE, 5};
    vec[7]  = '{1, 32'h9, 32'h3, 32'h0, 1'b0, 32'h3, 32'h0, 0, 32'h9, 32'h3, 32'h3, 1'b0, 32'h0, 4};
    vec[8]  = '{2, 32'h6, 32'h7, 32'h2A, 1'b0, 32'h0, 32'h0, 1, 32'h6, 32'h7, 32'h2A, 1'b0, 32'h0, 5};
    vec[9]  = '{1, 32'h9, 32'h3, 32'h0, 1'b0, 32'h3, 32'h0, 39, 32'h9, 32'h3, 32'h3, 1'b0, 32'h0, 43};
    vec[10] = '{1, 32'h9, 32'h3, 32'h0, 1'b0, 32'h3, 32'h0, 40, 32'h9, 32'h3, 32'h0, 1'b1, 32'h0, 43};
    vec[11] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 4};
    hold = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    set_dp(32'h0, 1'b0, 32'h0, 32'h0, 0);
    #1;
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_result", bus.data_result, 32'h0);
    chk("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
    #11 reset = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      set_dp(vec[i].prod, vec[i].ovf, vec[i].q, vec[i].r, vec[i].lat);
      issue(vec[i].op, vec[i].a, vec[i].b);
      chk($sformatf("v%0d_opa", i), bus.dp_operandA, vec[i].opa);
      chk($sformatf("v%0d_opb", i), bus.dp_operandB, vec[i].opb);
      chk($sformatf("v%0d_mstart", i), {31'b0, bus.dp_mult_start}, {31'b0, vec[i].op != 1});
      chk($sformatf("v%0d_dstart", i), {31'b0, bus.dp_div_start}, {31'b0, vec[i].op == 1 && vec[i].b != 0});
      chk($sformatf("v%0d_busy", i), {31'b0, bus.busy}, 32'h1);
      wait_rdy(n);
      chk($sformatf("v%0d_rdy_at", i), n, vec[i].rdy_at);
      chk($sformatf("v%0d_result", i), bus.data_result, vec[i].res);
      chk($sformatf("v%0d_exc", i), {31'b0, bus.data_exception}, {31'b0, vec[i].exc});
`ifdef MULTDIV_REMAINDER_EN
      chk($sformatf("v%0d_rem", i), bus.data_remainder, vec[i].rem);
`endif
      tick();
      chk($sformatf("v%0d_rdy_low", i), {31'b0, bus.data_resultRDY}, 32'h0);
      chk($sformatf("v%0d_idle", i), {31'b0, bus.busy}, 32'h0);
    end
    // abort a running divide with a multiply
    prev = bus.data_result;
    set_dp(32'h0, 1'b0, 32'h7, 32'h1, 10);
    issue(1, 32'd50, 32'd7);
    repeat (3) tick();
    rc = rdy_cnt;
    set_dp(32'd42, 1'b0, 32'h7, 32'h1, 3);
    issue(0, 32'd6, 32'd7);
    chk("abort_mstart", {31'b0, bus.dp_mult_start}, 32'h1);
    chk("abort_dstart", {31'b0, bus.dp_div_start}, 32'h0);
    chk("abort_held", bus.data_result, prev);
    wait_rdy(n);
    chk("abort_rdy_at", n, 7);
    chk("abort_result", bus.data_result, 32'd42);
    tick();
    tick();
    chk("abort_one_rdy", rdy_cnt - rc, 1);
    // divider never ready: watchdog
    hold = 1'b1;
    set_dp(32'h0, 1'b0, 32'h3, 32'h0, 0);
    issue(1, 32'd9, 32'd3);
    wait_rdy(n);
    chk("wd_rdy_at", n, 43);
    chk("wd_result", bus.data_result, 32'h0);
    chk("wd_exc", {31'b0, bus.data_exception}, 32'h1);
    hold = 1'b0;
    tick();
    // asynchronous reset while running
    set_dp(32'h0, 1'b0, 32'd14, 32'd2, 20);
    issue(1, 32'd100, 32'd7);
    repeat (5) tick();
    chk("ar_busy_pre", {31'b0, bus.busy}, 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("ar_busy", {31'b0, bus.busy}, 32'h0);
    chk("ar_opa", bus.dp_operandA, 32'h0);
    chk("ar_opb", bus.dp_operandB, 32'h0);
    chk("ar_exc", {31'b0, bus.data_exception}, 32'h0);
    @(negedge clock) reset = 1'b0;
    rc = rdy_cnt;
    repeat (50) tick();
    chk("ar_no_rdy", rdy_cnt - rc, 0);
    chk("ar_idle", {31'b0, bus.busy}, 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/multdiv_controller.md
Name: multdiv_controller

Overview:
- Sequencing FSM for the multdiv unit. It owns one iterative multiplier and one iterative divider; the divider accepts non-negative operands only.
- Latches an operation on a ctrl_MULT/ctrl_DIV pulse and starts the chosen datapath by pulsing its synchronous reset. It then waits for that datapath's ready flag, applies signed correction to division results and presents one registered result with a one-cycle ready pulse.
- Sits between the processor's multdiv interface and the mult/div datapaths.

Parameters:
- WIDTH, 32, operand and result width.
- MAX_CYCLES, 40, watchdog limit: maximum number of RUN-state cycles to wait for datapath ready before forcing an exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ctrl_MULT  in  1  one-cycle pulse: start multiply.
- ctrl_DIV  in  1  one-cycle pulse: start divide.
- data_operandA  in  WIDTH  operand A; sampled only in a ctrl pulse cycle.
- data_operandB  in  WIDTH  operand B; sampled only in a ctrl pulse cycle.
- dp_operandA  out  WIDTH  registered operand A to the datapath (absolute value for div).
- dp_operandB  out  WIDTH  registered operand B to the datapath (absolute value for div).
- dp_mult_start  out  1  one-cycle reset/start pulse to the multiplier.
- dp_div_start  out  1  one-cycle reset/start pulse to the divider.
- dp_mult_product  in  WIDTH  multiplier result.
- dp_mult_overflow  in  1  multiplier overflow.
- dp_mult_ready  in  1  multiplier done.
- dp_div_quotient  in  WIDTH  unsigned quotient.
- dp_div_remainder  in  WIDTH  unsigned remainder.
- dp_div_ready  in  1  divider done.
- data_result  out  WIDTH  final result; held until the next operation completes.
- data_exception  out  1  valid with data_resultRDY; held with data_result.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, cycle counter 0.

FSM states:
- IDLE -> START on a ctrl pulse.
- START lasts 1 cycle. The selected dp_*_start is high; the other start is low.
- RUN: the counter increments every cycle. Exit to FIX when the selected ready is high. Exit to FIX with the timeout flag set when counter == MAX_CYCLES-1.
- FIX lasts 1 cycle. It applies sign correction and registers data_result and data_exception.
- DONE lasts 1 cycle. data_resultRDY = 1, then -> IDLE.

Ctrl pulse capture:
- In the pulse cycle the block latches: op (mult/div), A, B, signA = A[WIDTH-1], signB = B[WIDTH-1].
- For div, dp_operandA/B = |A|, |B| as two's-complement negation when negative. |0x80000000| = 0x80000000, interpreted as unsigned.
- For mult, raw A and B are passed through.

Priority and pulses while busy:
- ctrl_MULT and ctrl_DIV high in the same cycle: MULT wins and DIV is dropped.
- A ctrl pulse in any non-IDLE state aborts the current op: no RDY for it. The block re-latches the new operands and goes to START next cycle.
- The previous data_result is kept until the new op reaches FIX.

Divide by zero:
- ctrl_DIV with B == 0 goes IDLE -> FIX directly, with no dp_div_start.
- Result 0, exception 1, RDY 2 cycles after the pulse.

Multiply result:
- data_result = dp_mult_product.
- data_exception = dp_mult_overflow.

Divide result:
- q = dp_div_quotient, negated if signA ^ signB.
- If A == 0x80000000, B == 0xFFFFFFFF: exception 1, result 0x80000000.
- Otherwise exception 0.

Timeout:
- data_result = 0, data_exception = 1.

Latency:
- pulse at cycle 0 -> START at 1 -> RUN from 2 -> FIX the cycle after ready is seen -> RDY the cycle after FIX.

Optional Feature:
- Macro: MULTDIV_REMAINDER_EN.
- Defined: adds output port data_remainder [WIDTH]. Its sign follows the dividend: dp_div_remainder, negated if signA. It is registered in FIX alongside data_result, is 0 on reset, divide-by-zero and timeout, and is 0 for mult.
- Undefined: no port, and no remainder logic or registers.

Test Plan:
- ctrl_MULT, A=7, B=-3 (0xFFFFFFFD), model ready 17 cycles after start -> one RDY pulse; data_result = 0xFFFFFFEB (-21), exception 0; busy low one cycle after RDY.
- ctrl_DIV, A=-17, B=5 -> dp_operandA=17, dp_operandB=5; datapath q=3 r=2 -> data_result = 0xFFFFFFFD (-3), exception 0; with MULTDIV_REMAINDER_EN, data_remainder = 0xFFFFFFFE (-2).
- ctrl_DIV, A=100, B=0 -> dp_div_start never asserts; RDY exactly 2 cycles after pulse; data_result 0, exception 1.
- ctrl_DIV A=0x80000000 B=0xFFFFFFFF -> exception 1, result 0x80000000. Then, with dp_div_ready held low, ctrl_DIV A=9 B=3 -> RDY after MAX_CYCLES RUN cycles, result 0, exception 1.
- ctrl_DIV A=50 B=7, then ctrl_MULT A=6 B=7 during RUN -> no RDY for the div; dp_mult_start pulses next cycle; single RDY with data_result 42.
- Assert reset asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; no RDY until a new ctrl pulse.
